cpu_int_arbiter: RTL and testbench
==================================

CPU_INT_ARBITER -- requirements
Module: cpu_int_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, the maximum number of cycles to wait for a device to drop its request after br_iack.
REQ-002 SHALL have parameter PIRQ_VEC, default 16'o000240, the vector returned for program interrupts.
REQ-003 wb_clk_i  in  1  single clock; all state changes on rising edge.
REQ-004 wb_rst_n_i  in  1  reset; asynchronous, active-low.
REQ-005 pir_in  in  16  PIRQ register; bits 15:9 = requests at levels 7..1.
REQ-006 psw_pri  in  3  current CPU priority (PSW[7:5]).
REQ-007 br_irq  in  4  device requests; bit n = level 4+n.
REQ-008 br_vec4, br_vec5, br_vec6, br_vec7  in  16 each  device vectors, valid while the matching br_irq is high.
REQ-009 br_iack  out  4  one-cycle acknowledge pulse to the granted device.
REQ-010 cpu_irq  out  1  interrupt pending to CPU.
REQ-011 cpu_ivec  out  16  vector of the granted request.
REQ-012 cpu_ipri  out  3  priority level of the granted request.
REQ-013 cpu_iack  in  1  CPU accepts pending interrupt (sampled while cpu_irq=1).
REQ-014 iack_timeout  out  1  one-cycle pulse when a device fails to drop its request within TIMEOUT.

Function
REQ-015 SHALL compute the PIRQ level as the index of the highest set bit in pir_in[15:9] (7..1), or 0 if none set.
REQ-016 SHALL compute the device level as 4+n for the highest set br_irq bit n, or 0 if none set.
REQ-017 A request SHALL be eligible only if its level > psw_pri; psw_pri=7 blocks all requests.
REQ-018 Winner selection: higher level wins; at equal level the device wins over PIRQ.
REQ-019 SHALL implement FSM states IDLE, GRANT, WAITDROP, RECOVER.
REQ-020 IDLE: if a winner is eligible at cycle N, SHALL latch level, vector (PIRQ_VEC for PIRQ) and source, enter GRANT, and drive cpu_irq=1 from cycle N+1.
REQ-021 GRANT: cpu_irq, cpu_ivec and cpu_ipri SHALL stay stable until exit.
REQ-022 GRANT with cpu_iack=1 at cycle M: cpu_irq=0 at M+1.
- device source: br_iack[n]=1 for cycle M+1 only; enter WAITDROP with counter cleared.
- PIRQ source: enter RECOVER; no br_iack.
REQ-023 GRANT with cpu_iack=0: SHALL cancel (cpu_irq=0 next cycle, return to IDLE) if any of the following holds:
- the latched request is withdrawn (device drops br_irq, or the PIRQ level is no longer set);
- the latched level is <= psw_pri;
- a strictly higher eligible request exists.
REQ-024 If cpu_iack and a cancel condition coincide, cpu_iack SHALL win.
REQ-025 WAITDROP: the counter increments each cycle.
- granted br_irq low -> RECOVER.
- counter reaches TIMEOUT with br_irq still high -> iack_timeout=1 for one cycle, then RECOVER.
REQ-026 RECOVER SHALL last exactly 2 cycles, then return to IDLE; no grant is made during RECOVER.
REQ-027 br_iack SHALL be one-hot or zero at all times.
REQ-028 cpu_ivec and cpu_ipri SHALL hold their last latched value outside GRANT.

Reset
REQ-029 When wb_rst_n_i=0 (asynchronous):
- FSM to IDLE, counter cleared;
- cpu_irq=0, cpu_ivec=0, cpu_ipri=0, br_iack=0, iack_timeout=0.
REQ-030 Reset asserted mid-GRANT or mid-WAITDROP SHALL drop all outputs immediately, with no br_iack or iack_timeout pulse.
REQ-031 After reset release, the first grant SHALL be possible on the first rising edge.

Verification
REQ-032 Reset with br_irq=4'hF, pir_in=16'o177000 -> all outputs 0 while reset is low; cpu_irq=1, cpu_ipri=7, cpu_ivec=br_vec7 one cycle after release.
REQ-033 pir_in=16'o002000, psw_pri=0 -> next cycle cpu_irq=1, cpu_ivec=16'o000240, cpu_ipri=2; cpu_iack pulse -> cpu_irq=0 next cycle, br_iack stays 0, no new grant for 2 cycles.
REQ-034 br_irq=4'b0010, br_vec5=16'o000060, pir_in=16'o020000, psw_pri=0 -> cpu_ivec=16'o000060, cpu_ipri=5; after cpu_iack, br_iack=4'b0010 for one cycle.
REQ-035 psw_pri=5, br_irq=4'b0010 -> cpu_irq stays 0; psw_pri set to 4 -> cpu_irq=1 one cycle later, cpu_ipri=5.
REQ-036 BR4 in GRANT, then BR6 asserted -> cpu_irq drops for one cycle, re-grants with cpu_ipri=6, cpu_ivec=br_vec6.
REQ-037 Device holds br_irq after br_iack -> iack_timeout pulses once TIMEOUT=16 cycles after br_iack; the next grant occurs no earlier than 2 cycles later.

Source files
------------

// File: rtl/cpu_int_arbiter_if.sv
// rtl/cpu_int_arbiter_if.sv - interrupt request/grant bundle between CPU, PIRQ and bus devices
interface cpu_int_arbiter_if;
  logic [15:0] pir_in;
  logic [2:0]  psw_pri;
  logic [3:0]  br_irq;
  logic [15:0] br_vec4;
  logic [15:0] br_vec5;
  logic [15:0] br_vec6;
  logic [15:0] br_vec7;
  logic [3:0]  br_iack;
  logic        cpu_irq;
  logic [15:0] cpu_ivec;
  logic [2:0]  cpu_ipri;
  logic        cpu_iack;
  logic        iack_timeout;

  modport slave (
    input  pir_in, psw_pri, br_irq, br_vec4, br_vec5, br_vec6, br_vec7, cpu_iack,
    output br_iack, cpu_irq, cpu_ivec, cpu_ipri, iack_timeout
  );

  modport master (
    output pir_in, psw_pri, br_irq, br_vec4, br_vec5, br_vec6, br_vec7, cpu_iack,
    input  br_iack, cpu_irq, cpu_ivec, cpu_ipri, iack_timeout
  );
endinterface

// File: rtl/cpu_int_arbiter.sv
// rtl/cpu_int_arbiter.sv - priority arbiter between program interrupts and BR4..BR7 devices
module cpu_int_arbiter #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [15:0] PIRQ_VEC = 16'o000240
) (
  input logic              wb_clk_i,
  input logic              wb_rst_n_i,
  cpu_int_arbiter_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_GRANT    = 2'd1;
  localparam logic [1:0] ST_WAITDROP = 2'd2;
  localparam logic [1:0] ST_RECOVER  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          rec_last;
  logic          lat_dev;
  logic [1:0]    lat_n;

  logic          cpu_irq_q;
  logic [15:0]   cpu_ivec_q;
  logic [2:0]    cpu_ipri_q;
  logic [3:0]    br_iack_q;
  logic          iack_timeout_q;

  logic [2:0]    pirq_lvl;
  logic [2:0]    dev_lvl;
  logic [1:0]    dev_n;
  logic [15:0]   dev_vec;
  logic          win_dev;
  logic [2:0]    win_lvl;
  logic          win_elig;
  logic          withdrawn;
  logic          cancel;

  always_comb begin
    pirq_lvl = 3'd0;
    for (int i = 9; i < 16; i++)
      if (bus.pir_in[i]) pirq_lvl = 3'(i - 8);
    dev_lvl = 3'd0;
    dev_n   = 2'd0;
    for (int i = 0; i < 4; i++)
      if (bus.br_irq[i]) begin
        dev_lvl = 3'(4 + i);
        dev_n   = 2'(i);
      end
  end

  always_comb begin
    case (dev_n)
      2'd0:    dev_vec = bus.br_vec4;
      2'd1:    dev_vec = bus.br_vec5;
      2'd2:    dev_vec = bus.br_vec6;
      default: dev_vec = bus.br_vec7;
    endcase
  end

  // A device ties with PIRQ at equal level and takes precedence.
  assign win_dev  = (dev_lvl != 3'd0) && (dev_lvl >= pirq_lvl);
  assign win_lvl  = win_dev ? dev_lvl : pirq_lvl;
  assign win_elig = win_lvl > bus.psw_pri;

  // PIRQ level n lives at pir_in[8+n]; {1'b1, lvl} forms that index directly.
  assign withdrawn = lat_dev ? !bus.br_irq[lat_n] : !bus.pir_in[{1'b1, cpu_ipri_q}];
  assign cancel    = withdrawn || (cpu_ipri_q <= bus.psw_pri) ||
                     (win_elig && (win_lvl > cpu_ipri_q));

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      rec_last       <= 1'b0;
      lat_dev        <= 1'b0;
      lat_n          <= 2'd0;
      cpu_irq_q      <= 1'b0;
      cpu_ivec_q     <= 16'd0;
      cpu_ipri_q     <= 3'd0;
      br_iack_q      <= 4'd0;
      iack_timeout_q <= 1'b0;
    end else begin
      br_iack_q      <= 4'd0;
      iack_timeout_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_elig) begin
            state      <= ST_GRANT;
            cpu_irq_q  <= 1'b1;
            cpu_ipri_q <= win_lvl;
            cpu_ivec_q <= win_dev ? dev_vec : PIRQ_VEC;
            lat_dev    <= win_dev;
            lat_n      <= dev_n;
          end
        end
        ST_GRANT: begin
          // CPU acknowledge outranks any simultaneous cancel condition.
          if (bus.cpu_iack) begin
            cpu_irq_q <= 1'b0;
            rec_last  <= 1'b0;
            if (lat_dev) begin
              br_iack_q <= 4'b0001 << lat_n;
              cnt       <= '0;
              state     <= ST_WAITDROP;
            end else begin
              state <= ST_RECOVER;
            end
          end else if (cancel) begin
            cpu_irq_q <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_WAITDROP: begin
          cnt <= cnt + 1'b1;
          if (!bus.br_irq[lat_n]) begin
            state <= ST_RECOVER;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            iack_timeout_q <= 1'b1;
            state          <= ST_RECOVER;
          end
        end
        default: begin
          if (rec_last) state <= ST_IDLE;
          rec_last <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cpu_irq      = cpu_irq_q;
  assign bus.cpu_ivec     = cpu_ivec_q;
  assign bus.cpu_ipri     = cpu_ipri_q;
  assign bus.br_iack      = br_iack_q;
  assign bus.iack_timeout = iack_timeout_q;

endmodule

// File: tb/tb_cpu_int_arbiter.sv
// tb/tb_cpu_int_arbiter.sv - directed bench for cpu_int_arbiter
module tb_cpu_int_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  cpu_int_arbiter_if bus();

  cpu_int_arbiter #(.TIMEOUT(16), .PIRQ_VEC(16'o000240)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    bus.br_irq   = 4'hF;
    bus.pir_in   = 16'o177000;
    bus.psw_pri  = 3'd0;
    bus.br_vec4  = 16'o000070;
    bus.br_vec5  = 16'o000060;
    bus.br_vec6  = 16'o000300;
    bus.br_vec7  = 16'o000310;
    bus.cpu_iack = 1'b0;
    tick(); tick(); tick();
    check("rst_irq",  32'(bus.cpu_irq), 32'd0);
    check("rst_ivec", 32'(bus.cpu_ivec), 32'd0);
    check("rst_ipri", 32'(bus.cpu_ipri), 32'd0);
    check("rst_iack", 32'(bus.br_iack), 32'd0);
    check("rst_tmo",  32'(bus.iack_timeout), 32'd0);

    // First grant right after release: BR7 beats PIRQ7.
    rst_n = 1'b1;
    tick();
    check("rel_irq",  32'(bus.cpu_irq), 32'd1);
    check("rel_ipri", 32'(bus.cpu_ipri), 32'd7);
    check("rel_ivec", 32'(bus.cpu_ivec), 32'o000310);

    // Reset mid-GRANT clears outputs without waiting for a clock.
    rst_n = 1'b0;
    #1;
    check("async_irq",  32'(bus.cpu_irq), 32'd0);
    check("async_ivec", 32'(bus.cpu_ivec), 32'd0);
    check("async_ipri", 32'(bus.cpu_ipri), 32'd0);
    bus.br_irq = 4'h0;
    bus.pir_in = 16'd0;
    tick();
    rst_n = 1'b1;
    tick();
    check("quiet_irq", 32'(bus.cpu_irq), 32'd0);

    // PIRQ level 2 grant and acknowledge.
    bus.pir_in = 16'o002000;
    tick();
    check("pirq_irq",  32'(bus.cpu_irq), 32'd1);
    check("pirq_ivec", 32'(bus.cpu_ivec), 32'o000240);
    check("pirq_ipri", 32'(bus.cpu_ipri), 32'd2);
    bus.cpu_iack = 1'b1;
    tick();
    bus.cpu_iack = 1'b0;
    check("pirq_ack_irq", 32'(bus.cpu_irq), 32'd0);
    check("pirq_no_br",   32'(bus.br_iack), 32'd0);
    tick();
    check("pirq_rec_irq", 32'(bus.cpu_irq), 32'd0);
    check("pirq_rec_br",  32'(bus.br_iack), 32'd0);
    tick(); tick();
    check("pirq_regrant", 32'(bus.cpu_irq), 32'd1);
    bus.pir_in = 16'd0;
    tick();
    check("pirq_withdraw", 32'(bus.cpu_irq), 32'd0);
    check("pirq_hold_vec", 32'(bus.cpu_ivec), 32'o000240);

    // BR5 ties with PIRQ5; device wins.
    bus.br_irq = 4'b0010;
    bus.pir_in = 16'o020000;
    tick();
    check("tie_irq",  32'(bus.cpu_irq), 32'd1);
    check("tie_ivec", 32'(bus.cpu_ivec), 32'o000060);
    check("tie_ipri", 32'(bus.cpu_ipri), 32'd5);
    bus.cpu_iack = 1'b1;
    tick();
    bus.cpu_iack = 1'b0;
    bus.br_irq   = 4'b0000;
    bus.pir_in   = 16'd0;
    check("tie_ack_irq", 32'(bus.cpu_irq), 32'd0);
    check("tie_br_iack", 32'(bus.br_iack), 32'b0010);
    tick();
    check("tie_br_pulse", 32'(bus.br_iack), 32'd0);
    tick(); tick(); tick();
    check("tie_idle", 32'(bus.cpu_irq), 32'd0);

    // Priority masking.
    bus.psw_pri = 3'd5;
    bus.br_irq  = 4'b0010;
    tick(); tick();
    check("mask_irq", 32'(bus.cpu_irq), 32'd0);
    bus.psw_pri = 3'd4;
    tick();
    check("unmask_irq",  32'(bus.cpu_irq), 32'd1);
    check("unmask_ipri", 32'(bus.cpu_ipri), 32'd5);
    bus.psw_pri = 3'd5;
    tick();
    check("raise_cancel", 32'(bus.cpu_irq), 32'd0);
    bus.psw_pri = 3'd7;
    bus.br_irq  = 4'b1000;
    bus.pir_in  = 16'o100000;
    tick(); tick();
    check("psw7_block", 32'(bus.cpu_irq), 32'd0);
    bus.pir_in  = 16'd0;

    // BR4 preempted by BR6 while pending.
    bus.psw_pri = 3'd0;
    bus.br_irq  = 4'b0001;
    tick();
    check("br4_ipri", 32'(bus.cpu_ipri), 32'd4);
    check("br4_ivec", 32'(bus.cpu_ivec), 32'o000070);
    bus.br_irq = 4'b0101;
    tick();
    check("preempt_drop", 32'(bus.cpu_irq), 32'd0);
    tick();
    check("preempt_irq",  32'(bus.cpu_irq), 32'd1);
    check("preempt_ipri", 32'(bus.cpu_ipri), 32'd6);
    check("preempt_ivec", 32'(bus.cpu_ivec), 32'o000300);

    // BR6 acknowledged but never drops its request.
    bus.br_irq   = 4'b0100;
    bus.cpu_iack = 1'b1;
    tick();
    bus.cpu_iack = 1'b0;
    check("to_br_iack", 32'(bus.br_iack), 32'b0100);
    for (int k = 1; k <= 15; k++) begin
      tick();
      check("to_quiet", 32'(bus.iack_timeout), 32'd0);
    end
    tick();
    check("to_pulse",     32'(bus.iack_timeout), 32'd1);
    check("to_pulse_irq", 32'(bus.cpu_irq), 32'd0);
    tick();
    check("to_one_cycle", 32'(bus.iack_timeout), 32'd0);
    check("to_rec_irq",   32'(bus.cpu_irq), 32'd0);
    tick();
    check("to_idle_irq",  32'(bus.cpu_irq), 32'd0);
    tick();
    check("to_regrant",      32'(bus.cpu_irq), 32'd1);
    check("to_regrant_ipri", 32'(bus.cpu_ipri), 32'd6);

    // Acknowledge coinciding with withdrawal: acknowledge wins.
    bus.cpu_iack = 1'b1;
    bus.br_irq   = 4'b0000;
    tick();
    bus.cpu_iack = 1'b0;
    check("race_br_iack", 32'(bus.br_iack), 32'b0100);
    check("race_irq",     32'(bus.cpu_irq), 32'd0);
    tick(); tick(); tick(); tick();
    check("race_idle",    32'(bus.cpu_irq), 32'd0);
    check("race_no_tmo",  32'(bus.iack_timeout), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
